smm_mul_share_arb: RTL and testbench
====================================

Name: smm_mul_share_arb

Overview:
- Round-robin arbiter and 2-stage pipeline sequencer that time-shares one signed 16x16->32 combinational multiplier cell among NUM_REQ requesters.
- Requesters are the conv/FC MAC lanes of the LeNet-5 SMM engine.
- Each accepted operand pair produces exactly one product on a shared response bus, tagged with the requester index.
- The response bus applies backpressure via rsp_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, tag width; must equal clog2(NUM_REQ), minimum 1
- A_W, 16, operand A width, signed
- B_W, 16, operand B width, signed
- P_W, 32, product width; must equal A_W+B_W

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*A_W  packed operand A; requester i at bits [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed operand B, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of the originating requester
- rsp_data  out  P_W  signed product
- busy  out  1  high while any pipeline stage holds data

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - s1_v, s2_v, rsp_valid and busy go to 0.
  - rr_ptr goes to NUM_REQ-1, so requester 0 has highest priority first.
  - rsp_id and rsp_data go to 0.
  - Reset mid-operation discards all in-flight operands; no response is emitted for them.
  - req_ready is 0 while ap_rst=1.
- Stage 1 (operand register): holds s1_v, s1_a, s1_b, s1_id.
- Stage 2 (product register): holds s2_v, s2_p, s2_id.
  - s2_p = the multiplier product of s1_a and s1_b.
  - s2_v, s2_p and s2_id drive rsp_valid, rsp_data and rsp_id directly.
- Advance conditions:
  - adv2 = !s2_v || rsp_ready
  - adv1 = !s1_v || adv2
- Arbitration:
  - Combinational, in the same cycle, when adv1=1.
  - Search order: requesters rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - The first requester with req_valid=1 receives req_ready=1.
  - When adv1=0, req_ready is all zero.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Handshake at requester i: req_valid[i] && req_ready[i].
  - Stage 1 loads {a_i, b_i, i} and s1_v becomes 1.
  - rr_ptr becomes i. rr_ptr changes only on a handshake.
  - No request with adv1=1: s1_v becomes 0 and rr_ptr is held.
- Stage movement:
  - When adv2=1: s2 loads s1 and s2_v takes the value of s1_v.
  - When adv2=0: stages 1 and 2 hold.
- Latency and throughput:
  - Handshake in cycle N gives rsp_valid in cycle N+2 when there is no backpressure.
  - Sustained throughput is 1 product per cycle.
- Backpressure: with rsp_ready=0 and both stages full, no new grant is issued and all registers hold.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_id and rsp_data remain stable.
- Arithmetic:
  - Two's-complement, full precision, no saturation or rounding.
  - -32768 * -32768 = 0x40000000.
- Ordering: responses leave in grant order. Maximum 2 products in flight.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- busy = s1_v || s2_v.

Decomposition:
- Package smm_mul_share_pkg holds:
  - the width constants A_W, B_W, P_W
  - the clog2 function
  - the response struct {id, data}
- Sub-module smm_rr_arbiter (NUM_REQ):
  - inputs: req vector, enable (=adv1), rr_ptr
  - outputs: one-hot grant and encoded grant index
  - purely combinational; the pointer register stays in the top module.
- The multiplier is the existing 16s x 16s -> 32 combinational multiplier cell, instanced once between stage 1 and stage 2.

Test Plan:
- Reset then single request: req_valid=0001, a=3, b=-5, rsp_ready=1 -> req_ready=0001 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0xFFFFFFF1 (-15).
- All four requesters asserting continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... with one response per cycle. Operand pairs (1,1),(2,2),(3,3),(4,4) return products 1,4,9,16 with matching rsp_id.
- Backpressure: 3 requests granted, then rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_data held; req_ready=0000 after the pipeline fills; no loss or duplication after release; total 3 responses.
- Corner operands: (-32768,-32768) -> 0x40000000; (32767,-32768) -> 0xC0008000; (0,-1) -> 0.
- Pointer fairness: only requesters 1 and 3 valid, starting with rr_ptr=3 -> grants alternate 1,3,1,3; rr_ptr stays 3 during idle gaps.
- Reset mid-operation: ap_rst=1 for 1 cycle with both stages full -> next cycle rsp_valid=0 and busy=0; the next grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/smm_mul_share_pkg.sv
// Shared widths, tag sizing helper and response record for the shared-multiplier arbiter.
// No logic: constants and types only.
// Backpressure: n/a.
package smm_mul_share_pkg;

    localparam int A_W      = 16;
    localparam int B_W      = 16;
    localparam int P_W      = A_W + B_W;
    localparam int MAX_ID_W = 3;

    // Bits needed to index n requesters, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0]    id;
        logic signed [P_W-1:0]  data;
    } rsp_t;

endpackage

// File: rtl/smm_mul16s.sv
// Signed 16x16 -> 32 combinational multiplier cell.
// Latency: combinational.
// Backpressure: n/a.
module smm_mul16s
    import smm_mul_share_pkg::*;
(
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/smm_rr_arbiter.sv
// Round-robin grant search starting just after rr_ptr.
// Latency: combinational.
// Backpressure: en low forces an all-zero grant.
module smm_rr_arbiter
    import smm_mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_any && req[idx]) begin
                    gnt_any      = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/smm_mul_share_arb.sv
// Time-shares one signed multiplier among NUM_REQ MAC lanes; round-robin grant, tagged products.
// Latency: handshake to rsp_valid is 2 cycles; one product per cycle sustained.
// Backpressure: rsp_ready low stalls the product stage; grants stop once both stages are full.
module smm_mul_share_arb
    import smm_mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_data,
    output logic                   busy
);

    logic                  adv1;
    logic                  adv2;
    logic                  s1_v;
    logic signed [A_W-1:0] s1_a;
    logic signed [B_W-1:0] s1_b;
    logic [ID_W-1:0]       s1_id;
    logic                  s2_v;
    rsp_t                  s2;
    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic signed [A_W-1:0] sel_a;
    logic signed [B_W-1:0] sel_b;
    logic signed [P_W-1:0] prod;
    logic                  unused_id_hi;

    assign adv2 = !s2_v || rsp_ready;
    assign adv1 = !s1_v || adv2;

    smm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .en      (adv1 && !ap_rst),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_a = req_a[gnt_idx*A_W +: A_W];
    assign sel_b = req_b[gnt_idx*B_W +: B_W];

    smm_mul16s u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_id   <= '0;
            s2_v    <= 1'b0;
            s2      <= '0;
            rr_ptr  <= ID_W'(NUM_REQ - 1);
        end else begin
            if (adv2) begin
                s2_v    <= s1_v;
                s2.id   <= MAX_ID_W'(s1_id);
                s2.data <= prod;
            end
            // rr_ptr moves only on an actual handshake so idle gaps keep fairness state.
            if (adv1) begin
                s1_v <= gnt_any;
                if (gnt_any) begin
                    s1_a   <= sel_a;
                    s1_b   <= sel_b;
                    s1_id  <= gnt_idx;
                    rr_ptr <= gnt_idx;
                end
            end
        end
    end

    assign req_ready    = gnt;
    assign rsp_valid    = s2_v;
    assign rsp_id       = s2.id[ID_W-1:0];
    assign rsp_data     = s2.data;
    assign busy         = s1_v || s2_v;
    assign unused_id_hi = &{1'b0, s2.id};

endmodule

// File: tb/tb_smm_mul_share_arb.sv
// Directed bench for smm_mul_share_arb: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_smm_mul_share_arb;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } log_t;

    typedef struct {
        int          id;
        logic [31:0] p;
        int          age;
    } ent_t;

    log_t rsp_log[$];
    log_t gnt_log[$];

    always #5 clk = ~clk;

    smm_mul_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
        .ap_clk    (clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] rsp_d(input int i);
        return (i < rsp_log.size()) ? rsp_log[i].data : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] rsp_i(input int i);
        return (i < rsp_log.size()) ? 32'(rsp_log[i].id) : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] gnt_i(input int i);
        return (i < gnt_log.size()) ? 32'(gnt_log[i].id) : 32'hxxxxxxxx;
    endfunction

    // Reference model: in-flight products as a queue; age 1 = just granted, age 2 = presented.
    initial begin
        ent_t        q[$];
        ent_t        e;
        int          mptr;
        int          gi;
        int          idx;
        bit          ev;
        bit          acc;
        bit          room;
        logic [3:0]  eg;
        logic signed [15:0] ta;
        logic signed [15:0] tbv;
        mptr = N - 1;
        forever begin
            @(negedge clk);
            ev = (q.size() > 0) && (q[0].age == 2);
            check("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_data", rsp_data, q[0].p);
            end
            check("busy", 32'(busy), 32'(q.size() > 0));
            acc  = ev && rsp_ready;
            room = !ap_rst && ((q.size() - int'(acc)) < 2);
            gi   = -1;
            eg   = '0;
            if (room) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (mptr + k) % N;
                    if (gi < 0 && req_valid[idx]) gi = idx;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(eg));
            if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), rsp_data, cyc});
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) gnt_log.push_back('{i, 32'h0, cyc});
            @(posedge clk);
            cyc++;
            if (ap_rst) begin
                q.delete();
                mptr = N - 1;
            end else begin
                if (acc) void'(q.pop_front());
                if (q.size() > 0) q[0].age = 2;
                if (gi >= 0) begin
                    ta     = req_a[gi*16 +: 16];
                    tbv    = req_b[gi*16 +: 16];
                    e.id   = gi;
                    e.p    = 32'(int'(ta) * int'(tbv));
                    e.age  = 1;
                    q.push_back(e);
                    mptr   = gi;
                end
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*16 +: 16] = 16'(a);
        req_b[i*16 +: 16] = 16'(b);
    endtask

    task automatic run_cycles(input int n, input bit oneshot);
        logic [3:0] hs;
        repeat (n) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (oneshot) req_valid = req_valid & ~hs;
        end
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        rsp_log.delete();
        gnt_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        req_valid = '0;
        do_reset();

        // Single request, -15 after two cycles
        set_op(0, 3, -5);
        req_valid = 4'b0001;
        run_cycles(4, 1'b1);
        check("t1_gnt_id", gnt_i(0), 32'd0);
        check("t1_rsp_id", rsp_i(0), 32'd0);
        check("t1_rsp_data", rsp_d(0), 32'hFFFFFFF1);
        check("t1_latency", 32'((rsp_log.size() > 0 && gnt_log.size() > 0) ?
              rsp_log[0].cyc - gnt_log[0].cyc : -1), 32'd2);

        // All four streaming: round-robin 0..3, one product per cycle
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, i + 1, i + 1);
        req_valid = 4'hF;
        run_cycles(8, 1'b0);
        req_valid = '0;
        run_cycles(3, 1'b0);
        for (int i = 0; i < 5; i++) check($sformatf("t2_gnt%0d", i), gnt_i(i), 32'(i % 4));
        check("t2_rsp0", rsp_d(0), 32'd1);
        check("t2_rsp1", rsp_d(1), 32'd4);
        check("t2_rsp2", rsp_d(2), 32'd9);
        check("t2_rsp3", rsp_d(3), 32'd16);
        check("t2_rsp3_id", rsp_i(3), 32'd3);
        check("t2_count", 32'(rsp_log.size()), 32'd8);
        check("t2_rate", 32'((rsp_log.size() > 3) ? rsp_log[3].cyc - rsp_log[0].cyc : -1), 32'd3);

        // Backpressure with both stages full
        do_reset();
        set_op(0, 5, 6);
        set_op(1, 7, -8);
        set_op(2, 9, 10);
        req_valid = 4'b0111;
        run_cycles(3, 1'b1);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(rsp_valid), 32'h1);
            check("t3_hold_id", 32'(rsp_id), 32'd1);
            check("t3_hold_data", rsp_data, 32'hFFFFFFC8);
            check("t3_hold_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        run_cycles(4, 1'b1);
        check("t3_count", 32'(rsp_log.size()), 32'd3);
        check("t3_d0", rsp_d(0), 32'd30);
        check("t3_d1", rsp_d(1), 32'hFFFFFFC8);
        check("t3_d2", rsp_d(2), 32'd90);
        check("t3_id2", rsp_i(2), 32'd2);

        // Corner operands
        do_reset();
        set_op(0, -32768, -32768);
        set_op(1, 32767, -32768);
        set_op(2, 0, -1);
        req_valid = 4'b0111;
        run_cycles(6, 1'b1);
        check("t4_minmin", rsp_d(0), 32'h40000000);
        check("t4_maxmin", rsp_d(1), 32'hC0008000);
        check("t4_zero", rsp_d(2), 32'h0);

        // Fairness between 1 and 3, pointer held over idle gap
        do_reset();
        set_op(1, 1, 1);
        set_op(3, 2, 2);
        req_valid = 4'b1010;
        run_cycles(3, 1'b0);
        req_valid = '0;
        run_cycles(3, 1'b0);
        req_valid = 4'b1010;
        run_cycles(2, 1'b0);
        req_valid = '0;
        run_cycles(3, 1'b0);
        check("t5_g0", gnt_i(0), 32'd1);
        check("t5_g1", gnt_i(1), 32'd3);
        check("t5_g2", gnt_i(2), 32'd1);
        check("t5_g3_after_idle", gnt_i(3), 32'd3);
        check("t5_g4", gnt_i(4), 32'd1);
        check("t5_count", 32'(gnt_log.size()), 32'd5);

        // Reset with both stages full
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, i + 2, 3);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        run_cycles(3, 1'b0);
        @(negedge clk);
        check("t6_full_busy", 32'(busy), 32'h1);
        check("t6_full_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #1;
        ap_rst = 1'b1;
        @(posedge clk);
        #1;
        ap_rst    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        rsp_log.delete();
        gnt_log.delete();
        @(negedge clk);
        check("t6_post_valid", 32'(rsp_valid), 32'h0);
        check("t6_post_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        run_cycles(1, 1'b0);
        req_valid = '0;
        run_cycles(4, 1'b0);
        check("t6_gnt", gnt_i(0), 32'd0);
        check("t6_gnt_count", 32'(gnt_log.size()), 32'd1);
        check("t6_rsp_count", 32'(rsp_log.size()), 32'd1);
        check("t6_rsp_data", rsp_d(0), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
